// File: rtl/ghpi_mem_arbiter.sv
// Two-requester GHPI arbiter: shares one memory port between instruction
// fetch (read-only) and data access, holding the grant for a whole
// transaction, with fixed or round-robin priority and a hung-slave watchdog.
module ghpi_mem_arbiter #(
  parameter int unsigned PRIORITY_MODE  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] imem_addr_i,
  input  logic        imem_valid_i,
  output logic [31:0] imem_data_o,
  output logic        imem_ack_o,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  input  logic [3:0]  dmem_sel_i,
  input  logic        dmem_we_i,
  input  logic        dmem_valid_i,
  output logic [31:0] dmem_data_o,
  output logic        dmem_ack_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_sel_o,
  output logic        mem_we_o,
  output logic        mem_valid_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i,
  output logic        timeout_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam bit                  WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned         TO_LAST   = WDOG_EN ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [TO_CNT_W-1:0] TO_LAST_C = TO_CNT_W'(TO_LAST);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                w_last_grant_nxt;
  logic [TO_CNT_W-1:0] r_to_cnt;
  logic [TO_CNT_W-1:0] w_to_cnt_nxt;
  logic                r_timeout_err;
  logic                w_timeout_err_nxt;

  logic w_req_valid;
  logic w_other_valid;
  logic w_timeout;
  logic w_grant_now;

  // Valid of the currently granted requester, and of the one waiting.
  assign w_req_valid   = (r_state == ST_BUSY_I) ? imem_valid_i :
                         (r_state == ST_BUSY_D) ? dmem_valid_i : 1'b0;
  assign w_other_valid = (r_state == ST_BUSY_I) ? dmem_valid_i :
                         (r_state == ST_BUSY_D) ? imem_valid_i : 1'b0;
  assign w_grant_now   = (r_state == ST_BUSY_D) ? GRANT_D : GRANT_I;

  // Watchdog fires on the last allowed wait cycle when the slave still stalls.
  assign w_timeout = WDOG_EN && w_req_valid && !mem_ack_i && (r_to_cnt == TO_LAST_C);

  // State, last-grant, watchdog and sticky error registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= GRANT_I;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  // Arbitration, completion hand-off, withdraw and watchdog next-state logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_last_grant_nxt  = r_last_grant;
    w_to_cnt_nxt      = r_to_cnt;
    w_timeout_err_nxt = r_timeout_err;
    case (r_state)
      ST_IDLE: begin
        w_to_cnt_nxt = '0;
        if (imem_valid_i && dmem_valid_i) begin
          if (PRIORITY_MODE == 0) begin
            w_state_nxt = ST_BUSY_D;
          end else begin
            w_state_nxt = (r_last_grant == GRANT_I) ? ST_BUSY_D : ST_BUSY_I;
          end
        end else if (dmem_valid_i) begin
          w_state_nxt = ST_BUSY_D;
        end else if (imem_valid_i) begin
          w_state_nxt = ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (!w_req_valid) begin
          // Requester withdrew: any slave ack this cycle is dropped.
          w_state_nxt  = ST_IDLE;
          w_to_cnt_nxt = '0;
        end else if (mem_ack_i) begin
          w_last_grant_nxt = w_grant_now;
          w_to_cnt_nxt     = '0;
          if (w_other_valid) begin
            w_state_nxt = (r_state == ST_BUSY_I) ? ST_BUSY_D : ST_BUSY_I;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_timeout) begin
          w_last_grant_nxt  = w_grant_now;
          w_to_cnt_nxt      = '0;
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = ST_IDLE;
        end else if (WDOG_EN) begin
          w_to_cnt_nxt = r_to_cnt + TO_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_to_cnt_nxt = '0;
      end
    endcase
  end

  // Shared-port datapath mux driven by the granted requester.
  always_comb begin
    mem_addr_o  = '0;
    mem_data_o  = '0;
    mem_sel_o   = '0;
    mem_we_o    = 1'b0;
    mem_valid_o = 1'b0;
    case (r_state)
      ST_BUSY_I: begin
        mem_addr_o  = imem_addr_i;
        mem_sel_o   = 4'b1111;
        mem_valid_o = imem_valid_i;
      end
      ST_BUSY_D: begin
        mem_addr_o  = dmem_addr_i;
        mem_data_o  = dmem_data_i;
        mem_sel_o   = dmem_sel_i;
        mem_we_o    = dmem_we_i;
        mem_valid_o = dmem_valid_i;
      end
      default: begin
      end
    endcase
  end

  // Ack routing; a watchdog completion returns zero data to the granted side.
  assign imem_ack_o    = (r_state == ST_BUSY_I) && imem_valid_i && (mem_ack_i || w_timeout);
  assign dmem_ack_o    = (r_state == ST_BUSY_D) && dmem_valid_i && (mem_ack_i || w_timeout);
  assign imem_data_o   = ((r_state == ST_BUSY_I) && w_timeout) ? 32'h0 : mem_data_i;
  assign dmem_data_o   = ((r_state == ST_BUSY_D) && w_timeout) ? 32'h0 : mem_data_i;
  assign timeout_err_o = r_timeout_err;

endmodule
